// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - state encodings and grant rule shared by the memory port arbiter
package mem_port_arbiter_pkg;

  localparam logic [1:0] ARBST_IDLE   = 2'd0;
  localparam logic [1:0] ARBST_BUSY_I = 2'd1;
  localparam logic [1:0] ARBST_BUSY_D = 2'd2;

  // Data side wins a tie unless it took the previous grant; a lone eligible port always wins.
  function automatic logic pick_data_port(input logic i_elig, input logic d_elig, input logic last_d);
    return d_elig & (~i_elig | ~last_d);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data stages; ARB_STATS_EN adds conflict_cnt
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 16
`ifdef ARB_STATS_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [WORD_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [WORD_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
`ifdef ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  conflict_cnt
`endif
);

  logic [1:0] state;
  logic       last_d;
  logic       i_elig;
  logic       d_elig;
  logic       grant_d;
  logic       grant_i;

  // A port is masked during its own ack cycle so a stale request is not granted again.
  always_comb begin
    i_elig  = i_req & ~i_ack;
    d_elig  = d_req & ~d_ack;
    grant_d = pick_data_port(i_elig, d_elig, last_d);
    grant_i = i_elig & ~grant_d;
  end

  assign stall_if  = i_req & ~i_ack;
  assign stall_mem = d_req & ~d_ack;

  // Arbitration FSM: grant from IDLE, hold the registered memory request until mem_ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARBST_IDLE;
      last_d    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        ARBST_IDLE: begin
          if (grant_d) begin
            state     <= ARBST_BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            last_d    <= 1'b1;
          end else if (grant_i) begin
            state    <= ARBST_BUSY_I;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= i_addr;
            last_d   <= 1'b0;
          end
        end
        ARBST_BUSY_I: begin
          if (mem_ready) begin
            i_rdata <= mem_rdata;
            i_ack   <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= ARBST_IDLE;
          end
        end
        ARBST_BUSY_D: begin
          if (mem_ready) begin
            d_rdata <= mem_rdata;
            d_ack   <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= ARBST_IDLE;
          end
        end
        default: begin
          state   <= ARBST_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  // Counts IDLE cycles where both ports compete for the grant; saturates at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conflict_cnt <= '0;
    end else if ((state == ARBST_IDLE) && i_elig && d_elig && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized self-checking bench for mem_port_arbiter
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;
`ifdef ARB_STATS_EN
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [WORD_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [WORD_W-1:0] d_wdata;
  logic              d_ack;
  logic [WORD_W-1:0] d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [WORD_W-1:0] mem_rdata;
  logic              stall_if;
  logic              stall_mem;
`ifdef ARB_STATS_EN
  logic [CNT_W-1:0]  conflict_cnt;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .WORD_W(WORD_W),
    .ADDR_W(ADDR_W)
`ifdef ARB_STATS_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
`ifdef ARB_STATS_EN
    ,
    .conflict_cnt(conflict_cnt)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference: one outstanding access record plus the "who went last" bit.
  bit              m_busy;
  bit              m_is_d;
  bit              m_we;
  bit [ADDR_W-1:0] m_addr;
  bit [WORD_W-1:0] m_wdata;
  bit              m_last_d;
  bit              m_i_ack;
  bit              m_d_ack;
  bit [WORD_W-1:0] m_i_rdata;
  bit [WORD_W-1:0] m_d_rdata;
  int              m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_busy = 0; m_is_d = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_last_d = 0;
    m_i_ack = 0; m_d_ack = 0; m_i_rdata = '0; m_d_rdata = '0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit i_el, d_el, take_d, n_i_ack, n_d_ack;
    i_el = i_req && !m_i_ack;
    d_el = d_req && !m_d_ack;
    n_i_ack = 0;
    n_d_ack = 0;
    if (!m_busy) begin
`ifdef ARB_STATS_EN
      if (i_el && d_el && m_cnt < CNT_MAX) m_cnt++;
`endif
      if (i_el || d_el) begin
        take_d = d_el && !(i_el && m_last_d);
        m_busy = 1;
        m_is_d = take_d;
        m_we = take_d ? d_we : 1'b0;
        m_addr = take_d ? d_addr : i_addr;
        if (take_d) m_wdata = d_wdata;
        m_last_d = take_d;
      end
    end else if (mem_ready) begin
      if (m_is_d) begin m_d_rdata = mem_rdata; n_d_ack = 1; end
      else begin m_i_rdata = mem_rdata; n_i_ack = 1; end
      m_busy = 0;
      m_we = 0;
    end
    m_i_ack = n_i_ack;
    m_d_ack = n_d_ack;
  endtask

  task automatic compare_all();
    check("mem_req", mem_req, m_busy);
    check("mem_we", mem_we, m_busy & m_we);
    if (m_busy) check("mem_addr", mem_addr, m_addr);
    if (m_busy && m_we) check("mem_wdata", mem_wdata, m_wdata);
    check("i_ack", i_ack, m_i_ack);
    check("d_ack", d_ack, m_d_ack);
    check("i_rdata", i_rdata, m_i_rdata);
    check("d_rdata", d_rdata, m_d_rdata);
    check("stall_if", stall_if, i_req & ~m_i_ack);
    check("stall_mem", stall_mem, d_req & ~m_d_ack);
    check("ack_exclusive", i_ack & d_ack, 1'b0);
`ifdef ARB_STATS_EN
    check("conflict_cnt", conflict_cnt, m_cnt);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_wdata", mem_wdata, 16'h0000);
    check("rst_i_ack", i_ack, 1'b0);
    check("rst_d_ack", d_ack, 1'b0);
    check("rst_i_rdata", i_rdata, 16'h0000);
    check("rst_d_rdata", d_rdata, 16'h0000);
    reset_n = 1;
  endtask

  task automatic drive_random();
    if (m_i_ack) begin
      i_req = 1'($urandom_range(0, 1));
      i_addr = 16'($urandom);
    end else if (i_req) begin
      if ($urandom_range(0, 31) == 0) i_req = 0;
    end else if ($urandom_range(0, 2) == 0) begin
      i_req = 1; i_addr = 16'($urandom);
    end
    if (m_d_ack) begin
      d_req = 1'($urandom_range(0, 1));
      d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
    end else if (d_req) begin
      if ($urandom_range(0, 31) == 0) d_req = 0;
    end else if ($urandom_range(0, 2) == 0) begin
      d_req = 1; d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
    end
    mem_ready = ($urandom_range(0, 9) < 6);
    mem_rdata = 16'($urandom);
  endtask

  initial begin
    logic [ADDR_W-1:0] grants[$];
    logic              prev_req;
    int                last_ack;

    reset_n = 0;
    idle_inputs();
    model_reset();
    apply_reset();

    // Lone fetch with a one-cycle memory.
    i_req = 1; i_addr = 16'h0010;
    cycle();
    check("t2_mem_req", mem_req, 1'b1);
    check("t2_mem_addr", mem_addr, 16'h0010);
    check("t2_mem_we", mem_we, 1'b0);
    check("t2_stall_if", stall_if, 1'b1);
    mem_ready = 1; mem_rdata = 16'hABCD;
    cycle();
    check("t2_i_ack", i_ack, 1'b1);
    check("t2_i_rdata", i_rdata, 16'hABCD);
    i_req = 0; mem_ready = 0;
    cycle();
    check("t2_i_ack_once", i_ack, 1'b0);

    // Lone store.
    d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 16'h1234;
    cycle();
    check("t3_mem_we", mem_we, 1'b1);
    check("t3_mem_addr", mem_addr, 16'h0200);
    check("t3_mem_wdata", mem_wdata, 16'h1234);
    mem_ready = 1; mem_rdata = 16'h7777;
    cycle();
    check("t3_d_ack", d_ack, 1'b1);
    check("t3_i_ack", i_ack, 1'b0);
    d_req = 0; mem_ready = 0;
    cycle();
    check("t3_d_ack_once", d_ack, 1'b0);

    // Reset in the middle of a data access; a late mem_ready must not produce an ack.
    d_req = 1; d_we = 0; d_addr = 16'h0400;
    cycle();
    check("t1_busy_mem_req", mem_req, 1'b1);
    #2 reset_n = 0;
    #1;
    check("t1_async_mem_req", mem_req, 1'b0);
    check("t1_async_i_ack", i_ack, 1'b0);
    check("t1_async_d_ack", d_ack, 1'b0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    reset_n = 1;
    mem_ready = 1; mem_rdata = 16'hDEAD;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("t1_late_ready_d_ack", d_ack, 1'b0);
      check("t1_late_ready_mem_req", mem_req, 1'b0);
    end

    // Simultaneous requests held continuously: grants alternate D, I, D, I.
    apply_reset();
    i_req = 1; i_addr = 16'h0100;
    d_req = 1; d_we = 0; d_addr = 16'h0300;
    mem_ready = 1; mem_rdata = 16'h5555;
    prev_req = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (mem_req && !prev_req) grants.push_back(mem_addr);
      prev_req = mem_req;
    end
    check("t4_grant_count", grants.size(), 4);
    while (grants.size() < 4) grants.push_back('x);
    check("t4_grant0_d", grants[0], 16'h0300);
    check("t4_grant1_i", grants[1], 16'h0100);
    check("t4_grant2_d", grants[2], 16'h0300);
    check("t4_grant3_i", grants[3], 16'h0100);
`ifdef ARB_STATS_EN
    check("t4_conflict_cnt", conflict_cnt, 1);
`endif

    // Stale fetch request held through every ack: acks exactly three cycles apart.
    apply_reset();
    i_req = 1; i_addr = 16'h0020; mem_ready = 1; mem_rdata = 16'h0F0F;
    last_ack = -1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (i_ack) begin
        if (last_ack >= 0) check("t5_ack_gap", k - last_ack, 3);
        last_ack = k;
      end
    end
    check("t5_saw_ack", last_ack >= 0, 1'b1);

    // Randomized traffic against the reference.
    apply_reset();
    for (int k = 0; k < 3000; k++) begin
      drive_random();
      cycle();
    end
`ifdef ARB_STATS_EN
    if (m_cnt == CNT_MAX) check("t6_cnt_saturated", conflict_cnt, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
